// File: rtl/apb_master_bridge.sv
// APB master bridge: a valid/ready command FIFO feeding an IDLE/SETUP/ACCESS APB sequencer.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS phases that wait too long for pready.
module apb_master_bridge #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);
    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int ENT_W = 1 + ADDR_W + DATA_W;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(CMD_DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t state, state_nxt;

    logic [ENT_W-1:0] fifo_mem [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             empty, push, pop, xfer_done, xfer_abort, tmo_hit;

    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("apb_master_bridge: CMD_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
    end

    // cmd_ready comes from the registered count only, so a same-cycle pop never frees a slot early
    assign empty     = (count == '0);
    assign cmd_ready = (count != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE) || !empty;
    assign psel      = (state != IDLE);
    assign penable   = (state == ACCESS);

    always_ff @(posedge pclk) begin
        if (push) fifo_mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: ;
            endcase
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Abort on the edge that would make the wait count reach TIMEOUT_CYCLES
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)                          tmo_cnt <= '0;
        else if (state == SETUP)               tmo_cnt <= '0;
        else if (state == ACCESS && !pready)   tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        xfer_done  = 1'b0;
        xfer_abort = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                if (pready) begin
                    xfer_done = 1'b1;
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = SETUP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (tmo_hit) begin
                    xfer_abort = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Response uses the pwrite of the finishing transfer, even when the next command loads on the same edge
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (pop) {pwrite, paddr, pwdata} <= fifo_mem[rd_ptr];
            rsp_valid <= xfer_done || xfer_abort;
            if (xfer_done || xfer_abort) begin
                rsp_write <= pwrite;
                rsp_rdata <= (xfer_done && !pwrite) ? prdata : '0;
                rsp_err   <= xfer_abort;
            end
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: APB RAM slave with programmable wait states, response scoreboard,
// table vectors, hand-timed latency/backpressure/reset/timeout sequences and a random phase.
module tb_apb_master_bridge;
    logic        pclk, presetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_write, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic [7:0]  paddr;
    logic        psel, penable, pwrite, pready;
    logic [31:0] pwdata, prdata;

    int n_checks = 0;
    int n_fail   = 0;

    apb_master_bridge #(.ADDR_W(8), .DATA_W(32), .CMD_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pready(pready), .prdata(prdata)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // APB RAM slave: wait_cfg pready-low cycles at the start of each ACCESS, stall holds pready low
    logic        stall = 1'b0;
    int          wait_cfg = 0;
    int          wait_cnt = 0;
    logic [31:0] slave_mem [256];
    assign pready = !stall && (wait_cnt == 0);
    assign prdata = slave_mem[paddr];

    always @(posedge pclk) begin
        if (psel && !penable) wait_cnt <= wait_cfg;
        else if (psel && penable) begin
            if (wait_cnt != 0)          wait_cnt <= wait_cnt - 1;
            else if (!stall && pwrite)  slave_mem[paddr] <= pwdata;
        end
    end

    // Reference model: RAM semantics applied in acceptance order
    typedef struct {
        logic        write;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] ref_mem [256];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic void model_accept(input logic w, input logic [7:0] a, input logic [31:0] d,
                                         input logic abort_exp);
        exp_t e;
        if (abort_exp) e = '{write: w, rdata: 32'h0, err: 1'b1};
        else if (w) begin
            ref_mem[a] = d;
            e = '{write: 1'b1, rdata: 32'h0, err: 1'b0};
        end else e = '{write: 1'b0, rdata: ref_mem[a], err: 1'b0};
        exp_q.push_back(e);
    endfunction

    // Scoreboard: every response pulse must match the oldest outstanding expectation
    always @(negedge pclk) begin
        exp_t e;
        if (presetn && rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 with no command outstanding");
            end else begin
                e = exp_q.pop_front();
                chk("sb_rsp_write", rsp_write, e.write);
                chk("sb_rsp_rdata", rsp_rdata, e.rdata);
                chk("sb_rsp_err", rsp_err, e.err);
            end
        end
    end

    // APB rule: address/direction/data captured in SETUP must hold through ACCESS
    logic [7:0]  s_addr;
    logic        s_write;
    logic [31:0] s_wdata;
    always @(negedge pclk) begin
        if (presetn && psel && !penable) begin
            s_addr  <= paddr;
            s_write <= pwrite;
            s_wdata <= pwdata;
        end
        if (presetn && penable) begin
            n_checks++;
            if (!psel || paddr !== s_addr || pwrite !== s_write || pwdata !== s_wdata) begin
                n_fail++;
                $display("FAIL apb_stable: got psel=%0b addr=%0h wr=%0b wdata=%0h required 1/%0h/%0b/%0h",
                         psel, paddr, pwrite, pwdata, s_addr, s_write, s_wdata);
            end
        end
    end

    task automatic send_cmd(input logic w, input logic [7:0] a, input logic [31:0] d, input logic abort_exp);
        int guard = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        while (!cmd_ready && guard < 200) begin
            @(posedge pclk); #1;
            guard++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL cmd_accept: got cmd_ready=0 for 200 cycles required 1");
            cmd_valid = 1'b0;
            return;
        end
        model_accept(w, a, d, abort_exp);
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, output logic w, output logic [31:0] d, output logic e);
        int c = 0;
        while (!rsp_valid && c < 200) begin
            @(posedge pclk); #1;
            c++;
        end
        chk({name, "_seen"}, rsp_valid, 1);
        w = rsp_write; d = rsp_rdata; e = rsp_err;
        @(posedge pclk); #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge pclk); #1;
        end
    endtask

    typedef struct {
        logic        write;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          waits;
        logic        exp_write;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        w, e;
        logic [31:0] d;
        int          got, drops, acc, c;
        int          tstamp[5];

        vecs[0] = '{1'b1, 8'hFF, 32'h0000_0001, 0, 1'b1, 32'h0000_0000};
        vecs[1] = '{1'b0, 8'hFF, 32'h0,         1, 1'b0, 32'h0000_0001};
        vecs[2] = '{1'b1, 8'h00, 32'h0000_0002, 2, 1'b1, 32'h0000_0000};
        vecs[3] = '{1'b0, 8'h00, 32'h0,         0, 1'b0, 32'h0000_0002};
        vecs[4] = '{1'b0, 8'h10, 32'h0,         0, 1'b0, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 8'h10, 32'hA5A5_5A5A, 3, 1'b1, 32'h0000_0000};
        vecs[6] = '{1'b0, 8'h10, 32'h0,         1, 1'b0, 32'hA5A5_5A5A};
        vecs[7] = '{1'b0, 8'h7F, 32'h0,         0, 1'b0, 32'h0000_0000};

        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = 32'h0;
            ref_mem[i]   = 32'h0;
        end
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h0; cmd_wdata = 32'h0;
        presetn = 1'b0;
        cyc(3);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp", {rsp_valid, rsp_write, rsp_err}, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        presetn = 1'b1;
        cyc(2);

        // Single write, zero-wait slave
        chk("lat_w_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 32'hDEAD_BEEF;
        model_accept(1'b1, 8'h10, 32'hDEAD_BEEF, 1'b0);
        cyc(1);
        cmd_valid = 1'b0;
        chk("lat_w_e0_psel", psel, 0);
        chk("lat_w_e0_busy", busy, 1);
        cyc(1);
        chk("lat_w_e1_sel_en", {psel, penable}, 2'b10);
        chk("lat_w_e1_bus", {pwrite, paddr, pwdata}, {1'b1, 8'h10, 32'hDEAD_BEEF});
        cyc(1);
        chk("lat_w_e2_sel_en", {psel, penable}, 2'b11);
        chk("lat_w_e2_rsp", rsp_valid, 0);
        cyc(1);
        chk("lat_w_e3_rsp", {rsp_valid, rsp_write, rsp_err}, 3'b110);
        chk("lat_w_e3_rdata", rsp_rdata, 0);
        chk("lat_w_e3_psel", psel, 0);
        cyc(1);
        chk("lat_w_e4_rsp", rsp_valid, 0);
        chk("lat_w_e4_busy", busy, 0);

        // Read with one wait state
        wait_cfg = 1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10; cmd_wdata = 32'h0;
        model_accept(1'b0, 8'h10, 32'h0, 1'b0);
        cyc(1);
        cmd_valid = 1'b0;
        cyc(1);
        chk("lat_r_e1_sel_en", {psel, penable}, 2'b10);
        cyc(1);
        chk("lat_r_e2_sel_en", {psel, penable}, 2'b11);
        cyc(1);
        chk("lat_r_e3_sel_en", {psel, penable}, 2'b11);
        chk("lat_r_e3_rsp", rsp_valid, 0);
        cyc(1);
        chk("lat_r_e4_rsp", {rsp_valid, rsp_write, rsp_err}, 3'b100);
        chk("lat_r_e4_rdata", rsp_rdata, 32'hDEAD_BEEF);
        cyc(2);

        // Table vectors, including address boundaries 0x00/0xFF
        for (int i = 0; i < 8; i++) begin
            wait_cfg = vecs[i].waits;
            send_cmd(vecs[i].write, vecs[i].addr, vecs[i].wdata, 1'b0);
            wait_rsp($sformatf("vec%0d", i), w, d, e);
            chk($sformatf("vec%0d_write", i), w, vecs[i].exp_write);
            chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), e, 0);
        end
        wait_cfg = 0;

        // Five commands against a stalled slave: one in flight, four fill the FIFO
        stall = 1'b1;
        send_cmd(1'b1, 8'h30, 32'h0000_0111, 1'b0);
        send_cmd(1'b0, 8'h30, 32'h0,         1'b0);
        send_cmd(1'b1, 8'h30, 32'h0000_0222, 1'b0);
        send_cmd(1'b0, 8'h30, 32'h0,         1'b0);
        send_cmd(1'b0, 8'hFF, 32'h0,         1'b0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_full_ready%0d", i), cmd_ready, 0);
            cyc(1);
        end
        chk("bp_stalled_access", {psel, penable, busy}, 3'b111);
        stall = 1'b0;
        got = 0; drops = 0;
        for (int k = 0; k < 60 && got < 5; k++) begin
            cyc(1);
            if (rsp_valid) begin
                tstamp[got] = k;
                got++;
            end
            if (got < 5 && !psel) drops++;
        end
        chk("bp_all_done", got, 5);
        chk("bp_psel_drops", drops, 0);
        for (int i = 1; i < 5; i++) chk($sformatf("bp_gap%0d", i), tstamp[i] - tstamp[i-1], 2);
        cyc(2);

        // Reset in ACCESS with two commands queued
        stall = 1'b1;
        send_cmd(1'b0, 8'h00, 32'h0, 1'b0);
        send_cmd(1'b0, 8'hFF, 32'h0, 1'b0);
        send_cmd(1'b0, 8'h10, 32'h0, 1'b0);
        c = 0;
        while (!penable && c < 20) begin
            cyc(1);
            c++;
        end
        chk("rstx_in_access", penable, 1);
        #2 presetn = 1'b0;
        #1;
        chk("rstx_sel_en", {psel, penable}, 2'b00);
        chk("rstx_busy", busy, 0);
        chk("rstx_ready", cmd_ready, 1);
        exp_q.delete();
        cyc(2);
        presetn = 1'b1;
        stall = 1'b0;
        got = 0;
        for (int k = 0; k < 12; k++) begin
            cyc(1);
            if (rsp_valid) got++;
        end
        chk("rstx_no_rsp", got, 0);
        chk("rstx_idle", busy, 0);

        // ACCESS held with pready low: timeout abort when enabled, indefinite wait otherwise
        stall = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
        send_cmd(1'b0, 8'h00, 32'h0, 1'b1);
        send_cmd(1'b0, 8'h00, 32'h0, 1'b0);
        acc = 0;
        for (int k = 0; k < 100 && !rsp_valid; k++) begin
            if (penable) acc++;
            cyc(1);
        end
        chk("tmo_access_cycles", acc, 16);
        chk("tmo_rsp", {rsp_valid, rsp_err, rsp_write}, 3'b110);
        chk("tmo_rdata", rsp_rdata, 0);
        chk("tmo_psel", psel, 0);
        stall = 1'b0;
        cyc(1);
        wait_rsp("tmo_next", w, d, e);
        chk("tmo_next_err", e, 0);
        chk("tmo_next_rdata", d, 32'h0000_0002);
`else
        send_cmd(1'b0, 8'h00, 32'h0, 1'b0);
        send_cmd(1'b0, 8'hFF, 32'h0, 1'b0);
        acc = 0;
        for (int k = 0; k < 40; k++) begin
            cyc(1);
            if (penable && !rsp_valid) acc++;
        end
        chk("hold_access_cycles", acc, 40);
        stall = 1'b0;
        wait_rsp("hold_first", w, d, e);
        chk("hold_first_err", e, 0);
        chk("hold_first_rdata", d, 32'h0000_0002);
`endif
        cyc(8);

        // Random traffic against the scoreboard
        for (int i = 0; i < 150; i++) begin
            logic [7:0] a;
            wait_cfg = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) a = 8'hFF - 8'($urandom_range(0, 3));
            else                           a = 8'($urandom_range(0, 7));
            send_cmd(1'($urandom_range(0, 1)), a, $urandom, 1'b0);
            if ($urandom_range(0, 2) == 0) cyc($urandom_range(1, 4));
        end
        c = 0;
        while ((exp_q.size() != 0 || busy) && c < 2000) begin
            cyc(1);
            c++;
        end
        chk("drain_outstanding", exp_q.size(), 0);
        chk("drain_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
